// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencing
// controller and the load-use comparator.
package pipe_ctrl_pkg;

  // Sequencing FSM states
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } pipe_state_e;

  // Default register-number width (32 architectural registers)
  localparam int REG_W_DEF = 5;

  // Register $zero is never a real producer, so it never causes a hazard
  localparam int ZERO_REG = 0;

  // Per-stage control bundle, MSB first:
  // pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } stage_ctrl_t;

  // Normal flow: every register loads, nothing squashed
  localparam stage_ctrl_t CTRL_RUN    = 8'b1111_1000;
  // Memory freeze: every register holds, nothing squashed
  localparam stage_ctrl_t CTRL_FROZEN = 8'b0000_0000;
  // Taken branch: everything loads, three wrong-path slots become bubbles
  localparam stage_ctrl_t CTRL_BRANCH = 8'b1111_1111;
  // Load-use: PC and IF/ID hold, a bubble is inserted into EX
  localparam stage_ctrl_t CTRL_STALL  = 8'b0011_1010;
  // Reset: nothing loads, every flushable register is forced to a bubble
  localparam stage_ctrl_t CTRL_RESET  = 8'b0000_0111;

  // Select the advancing-pipeline control word: branch beats load-use
  function automatic stage_ctrl_t advance_ctrl(input logic br_taken, input logic hz);
    stage_ctrl_t c;
    if (br_taken) begin
      c = CTRL_BRANCH;
    end else if (hz) begin
      c = CTRL_STALL;
    end else begin
      c = CTRL_RUN;
    end
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: pure combinational load-use hazard comparator.
// Flags when the load in EX writes a register the ID instruction reads.
// Also instantiated by the forwarding unit.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hz
);

  logic rs_match;
  logic rt_match;
  logic dst_live;

  // Compare the load destination against both ID sources
  always_comb begin
    dst_live = (ex_rt != REG_W'(ZERO_REG));
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt && (ex_rt == id_rt);
    hz       = ex_mem_read && dst_live && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage enable/flush sequencing for the 5-stage core.
// Handles load-use stalls, taken-branch flushes resolved in MEM, and
// freezes on a multi-cycle data-memory access with a timeout.
// Optional feature macro: PIPE_HAZ_PERF_EN adds saturating stall and
// branch-flush counters; without it both count ports are tied to zero.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_W       = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_err,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count
);

  // Last wait-counter value before the access is abandoned
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  pipe_state_e state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        hz;
  logic        advance;
  stage_ctrl_t ctrl;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_hz (
    .ex_mem_read(ex_mem_read),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hz         (hz)
  );

  // Next-state, wait counter and Mealy stage-control decode
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    advance    = 1'b0;
    ctrl       = CTRL_FROZEN;

    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          // Access not done this cycle: freeze everything and start waiting
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end else begin
          advance = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_d = ST_RUN;
          advance = 1'b1;
        end else if (wait_cnt_q == TMO_LAST) begin
          // Give up: let the instruction move on and record the error
          state_d   = ST_RUN;
          mem_err_d = 1'b1;
          advance   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Branch and load-use are only honoured when the pipeline advances
    if (advance) begin
      ctrl = advance_ctrl(br_taken, hz);
    end else begin
      ctrl = CTRL_FROZEN;
    end

    // Reset overrides asynchronously: hold everything, bubble every stage
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else begin
      ctrl = ctrl;
    end
  end

  // FSM state, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign mem_err     = mem_err_q;

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: PC-held cycles and executed branch flushes
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl.pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    // Outside reset only a taken branch squashes IF/ID
    if (ctrl.ifid_flush && rst_n && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Expected control words are pushed to a scoreboard queue as each step is
// driven and popped when the outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] E_RUN    = 8'b1111_1000;
  localparam logic [7:0] E_FROZEN = 8'b0000_0000;
  localparam logic [7:0] E_BRANCH = 8'b1111_1111;
  localparam logic [7:0] E_STALL  = 8'b0011_1010;
  localparam logic [7:0] E_RESET  = 8'b0000_0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, br_taken, mem_req, mem_ack;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, mem_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  typedef struct packed {
    logic [7:0]  ef;
    logic        err;
    logic [31:0] stall;
    logic [15:0] fl;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_stall  = 0;
  int   m_flush  = 0;
  logic m_err    = 1'b0;

  wire [7:0] dut_ef = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .REG_W      (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .br_taken    (br_taken),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  task automatic push_exp(input logic [7:0] ef);
    exp_t e;
    e.ef  = ef;
    e.err = m_err;
`ifdef PIPE_HAZ_PERF_EN
    e.stall = 32'(m_stall);
    e.fl    = 16'(m_flush);
`else
    e.stall = 32'd0;
    e.fl    = 16'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty got=%0d exp=1", tag, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      assert (dut_ef === e.ef) else begin
        failures++;
        $error("FAIL %s.en_flush got=%b exp=%b", tag, dut_ef, e.ef);
      end
      checks++;
      assert (mem_err === e.err) else begin
        failures++;
        $error("FAIL %s.mem_err got=%b exp=%b", tag, mem_err, e.err);
      end
      checks++;
      assert (stall_cycles === e.stall) else begin
        failures++;
        $error("FAIL %s.stall_cycles got=%0d exp=%0d", tag, stall_cycles, e.stall);
      end
      checks++;
      assert (flush_count === e.fl) else begin
        failures++;
        $error("FAIL %s.flush_count got=%0d exp=%0d", tag, flush_count, e.fl);
      end
    end
  endtask

  // One clock cycle: expect ef with the current inputs, then take the edge
  task automatic cyc(input string tag, input logic [7:0] ef);
    push_exp(ef);
    @(negedge clk);
    pop_check(tag);
    if (ef[7] == 1'b0) m_stall++;
    if (ef[2] == 1'b1) m_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    ex_rt       = 5'd0;
    id_uses_rt  = 1'b0;
    ex_mem_read = 1'b0;
    br_taken    = 1'b0;
    mem_req     = 1'b0;
    mem_ack     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    push_exp(E_RESET);
    pop_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cyc("idle", E_RUN);

    // Load-use on rs: one stall cycle, then the load's bubble clears it
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    cyc("lu_rs", E_STALL);
    ex_mem_read = 1'b0;
    cyc("lu_rs_after", E_RUN);

    // $zero destination never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    cyc("lu_zero", E_RUN);

    // rt match only counts when the instruction reads rt
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    cyc("lu_rt", E_STALL);
    id_uses_rt = 1'b0;
    cyc("lu_rt_unused", E_RUN);

    // Branch wins over a simultaneous load-use
    id_rs = 5'd9; br_taken = 1'b1;
    cyc("br_hz", E_BRANCH);
    idle_inputs();

    // Same-cycle ack: no freeze
    mem_req = 1'b1; mem_ack = 1'b1;
    cyc("mem_fast", E_RUN);

    // Ack after three frozen cycles
    mem_ack = 1'b0;
    cyc("mw_0", E_FROZEN);
    cyc("mw_1", E_FROZEN);
    cyc("mw_2", E_FROZEN);
    mem_ack = 1'b1;
    cyc("mw_ack", E_RUN);
    idle_inputs();
    cyc("mw_after", E_RUN);

    // Branch held during a freeze is acted on at the ack
    mem_req = 1'b1; br_taken = 1'b1;
    cyc("bf_enter", E_FROZEN);
    cyc("bf_wait", E_FROZEN);
    mem_ack = 1'b1;
    cyc("bf_ack", E_BRANCH);
    idle_inputs();
    cyc("bf_after", E_RUN);

    // Reset during MEM_WAIT abandons the access without an error
    mem_req = 1'b1;
    cyc("rw_enter", E_FROZEN);
    push_exp(E_FROZEN);
    #2;
    pop_check("rw_wait");
    rst_n   = 1'b0;
    m_stall = 0;
    m_flush = 0;
    #1;
    push_exp(E_RESET);
    pop_check("rw_async");
    @(posedge clk);
    #1;
    push_exp(E_RESET);
    pop_check("rw_held");
    @(negedge clk);
    rst_n   = 1'b1;
    mem_req = 1'b0;
    @(posedge clk);
    #1;
    cyc("rw_release", E_RUN);

    // Timeout after four wait cycles; mem_err is sticky
    mem_req = 1'b1;
    cyc("to_enter", E_FROZEN);
    cyc("to_w1", E_FROZEN);
    cyc("to_w2", E_FROZEN);
    cyc("to_w3", E_FROZEN);
    cyc("to_expire", E_RUN);
    m_err   = 1'b1;
    mem_req = 1'b0;
    cyc("to_after", E_RUN);
    cyc("to_sticky", E_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
